multi_debouncer: RTL and testbench

Parametrised successor to the single-input button debouncer. Debounces NUM_CH asynchronous inputs (buttons, switches) in parallel. Each channel has its own synchroniser, stability counter, and registered rising/falling edge pulses. Sits between board pins and the control FSMs, so downstream logic consumes clean levels and single-cycle press/release strobes.

---
 rtl/multi_debouncer.sv | 171 +++++++++++++++++
 tb/tb_multi_debouncer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer
//
// Debounces NUM_CH asynchronous inputs in parallel. Each channel runs its own
// SYNC_STAGES-deep synchroniser, a stability counter that accepts a new level
// only after DEBOUNCE_CYCLES consecutive differing samples, and registered
// one-cycle rise/fall strobes that coincide with the first cycle of the new level.
//
// Optional feature: define MULTI_DEBOUNCER_REPEAT_EN to build per-channel
// auto-repeat counters. When it is undefined, btn_repeat is tied to 0.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   btn_in     in   [NUM_CH] raw asynchronous inputs
//   btn_out    out  [NUM_CH] debounced levels
//   btn_rise   out  [NUM_CH] one-cycle strobe on accepted 0->1
//   btn_fall   out  [NUM_CH] one-cycle strobe on accepted 1->0
//   btn_repeat out  [NUM_CH] auto-repeat strobes (0 unless the feature is built)

module multi_debouncer #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_out,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_repeat
);

    // Elaboration-time parameter sanity checks.
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("multi_debouncer: NUM_CH must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("multi_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("multi_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_debouncer: SYNC_STAGES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("multi_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  sync_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= btn_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stability counters and debounced levels
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            out_q, out_d;
    logic [NUM_CH-1:0]            rise_q, rise_d;
    logic [NUM_CH-1:0]            fall_q, fall_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sync_s[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                out_d[i] = sync_s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Strobes are registered alongside the level, so they line up with the
    // first cycle in which btn_out shows the new value.
    assign rise_d = out_d & ~out_q;
    assign fall_d = ~out_d & out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign btn_out  = out_q;
    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RcntW  = $clog2(RepMax + 1);
    localparam logic [RcntW-1:0] DlyMax = RcntW'(REPEAT_DELAY - 1);
    localparam logic [RcntW-1:0] PerMax = RcntW'(REPEAT_PERIOD - 1);

    logic [NUM_CH-1:0][RcntW-1:0] rcnt_q, rcnt_d;
    // Set after the first repeat pulse; selects PERIOD instead of DELAY as target.
    logic [NUM_CH-1:0]            armed_q, armed_d;
    logic [NUM_CH-1:0]            rep_q, rep_d;

    always_comb begin
        rcnt_d  = rcnt_q;
        armed_d = armed_q;
        rep_d   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // Idle while released, and clear in the release cycle itself.
            if (!out_q[i] || !out_d[i]) begin
                rcnt_d[i]  = '0;
                armed_d[i] = 1'b0;
            end else if (rcnt_q[i] == (armed_q[i] ? PerMax : DlyMax)) begin
                rep_d[i]   = 1'b1;
                rcnt_d[i]  = '0;
                armed_d[i] = 1'b1;
            end else begin
                rcnt_d[i] = rcnt_q[i] + RcntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q  <= '0;
            armed_q <= '0;
            rep_q   <= '0;
        end else begin
            rcnt_q  <= rcnt_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
        end
    end

    assign btn_repeat = rep_q;
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
`timescale 1ns / 1ps

module tb_multi_debouncer;

    localparam int unsigned NumCh = 4;

`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [NumCh-1:0] btn_in;
    logic [NumCh-1:0] btn_out;
    logic [NumCh-1:0] btn_rise;
    logic [NumCh-1:0] btn_fall;
    logic [NumCh-1:0] btn_repeat;

    int passed = 0;
    int total  = 0;

    multi_debouncer #(
        .NUM_CH         (NumCh),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .SYNC_STAGES    (2),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (6)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .btn_out   (btn_out),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-run monitors sampled away from the active edge.
    int overlap_cnt = 0;
    int rise1_cnt   = 0;
    int fall1_cnt   = 0;
    int rep0_cnt    = 0;
    int rep_any_cnt = 0;
    always @(negedge clk) begin
        if ((btn_rise & btn_fall) != '0) overlap_cnt++;
        if (btn_rise[1]) rise1_cnt++;
        if (btn_fall[1]) fall1_cnt++;
        if (btn_repeat[0]) rep0_cnt++;
        if (btn_repeat != '0) rep_any_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base_r;
        int base_f;
        int first_hi;
        int seen;
        int rep_base;

        // ---------------- reset ----------------
        reset_n = 1'b0;
        btn_in  = 4'hF;
        step(3);
        chk("rst_hold_out", 32'(btn_out), 32'h0);
        chk("rst_hold_rise", 32'(btn_rise), 32'h0);
        reset_n = 1'b1;
        step(1);
        chk("rst_rel_out", 32'(btn_out), 32'h0);
        chk("rst_rel_strobes", 32'({btn_rise, btn_fall, btn_repeat}), 32'h0);
        step(8);
        chk("rst_out_before", 32'(btn_out), 32'h0);
        step(1);
        chk("rst_out_after", 32'(btn_out), 32'hF);
        chk("rst_rise_pulse", 32'(btn_rise), 32'hF);
        step(1);
        chk("rst_rise_gone", 32'(btn_rise), 32'h0);
        chk("rst_out_held", 32'(btn_out), 32'hF);

        // ---------------- ch0 falls, then glitch ----------------
        btn_in[0] = 1'b0;
        step(9);
        chk("fall0_before", 32'(btn_out), 32'hF);
        step(1);
        chk("fall0_out", 32'(btn_out), 32'hE);
        chk("fall0_pulse", 32'(btn_fall), 32'h1);
        step(1);
        chk("fall0_gone", 32'(btn_fall), 32'h0);

        btn_in[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 7; c++) begin
            step(1);
            seen = seen | int'(btn_out[0] | btn_rise[0] | btn_fall[0]);
        end
        btn_in[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            seen = seen | int'(btn_out[0] | btn_rise[0] | btn_fall[0]);
        end
        chk("glitch_no_change", 32'(seen), 32'h0);
        chk("glitch_out", 32'(btn_out), 32'hE);

        // ---------------- ch1 bounce then settle ----------------
        btn_in[1] = 1'b0;
        step(12);
        chk("ch1_low", 32'(btn_out), 32'hC);
        base_r = rise1_cnt;
        base_f = fall1_cnt;
        for (int k = 0; k < 10; k++) begin
            btn_in[1] = (k % 2 == 0);
            step(3);
        end
        btn_in[1] = 1'b1;
        first_hi = -1;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (first_hi < 0 && btn_out[1]) first_hi = c;
        end
        chk("bounce_latency", 32'(first_hi), 32'd10);
        chk("bounce_one_rise", 32'(rise1_cnt - base_r), 32'd1);
        chk("bounce_no_fall", 32'(fall1_cnt - base_f), 32'd0);

        // ---------------- independence ----------------
        btn_in[2] = 1'b0;
        step(12);
        chk("ch2_low", 32'(btn_out), 32'hA);
        btn_in[2] = 1'b1;
        btn_in[3] = 1'b0;
        step(9);
        chk("indep_before", 32'(btn_out), 32'hA);
        step(1);
        chk("indep_out", 32'(btn_out), 32'h6);
        chk("indep_rise", 32'(btn_rise), 32'h4);
        chk("indep_fall", 32'(btn_fall), 32'h8);
        step(1);
        chk("indep_gone", 32'({btn_rise, btn_fall}), 32'h0);

        // ---------------- async reset mid-count ----------------
        btn_in[0] = 1'b1;
        step(7);
        #1 reset_n = 1'b0;
        #0.5;
        chk("async_out", 32'(btn_out), 32'h0);
        chk("async_strobes", 32'({btn_rise, btn_fall, btn_repeat}), 32'h0);
        #0.5 reset_n = 1'b1;
        step(1);
        step(8);
        chk("async_restart_before", 32'(btn_out), 32'h0);
        step(1);
        chk("async_restart_out", 32'(btn_out), 32'h7);
        chk("async_restart_rise", 32'(btn_rise), 32'h7);

        // ---------------- auto-repeat ----------------
        rep_base = rep_any_cnt;
        step(19);
        chk("rep_none_early", 32'(rep_any_cnt - rep_base), 32'd0);
        step(1);
        chk("rep_first", 32'(btn_repeat), RepEn ? 32'h7 : 32'h0);
        step(1);
        chk("rep_first_gone", 32'(btn_repeat), 32'h0);
        step(4);
        chk("rep_gap", 32'(btn_repeat), 32'h0);
        step(1);
        chk("rep_second", 32'(btn_repeat), RepEn ? 32'h7 : 32'h0);
        step(6);
        chk("rep_third", 32'(btn_repeat), RepEn ? 32'h7 : 32'h0);

        btn_in[0] = 1'b0;
        step(10);
        chk("rel_out", 32'(btn_out), 32'h6);
        rep_base = rep0_cnt;
        step(30);
        chk("rel_no_rep0", 32'(rep0_cnt - rep_base), 32'd0);

        chk("no_rise_fall_overlap", 32'(overlap_cnt), 32'd0);
        if (!RepEn) chk("repeat_tied_low", 32'(rep_any_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
